// File: rtl/dcache_mem_ctl_if.sv
// Word-wide memory bus between the line-fill engine and main memory.
// Requests are held until acked; one beat per req & ack cycle.
interface dcache_mem_ctl_if #(
  parameter int ADDR_BITS = 32,
  parameter int WORD_BITS = 32
);
  logic                 o_mem_req;
  logic                 o_mem_we;
  logic [ADDR_BITS-1:0] o_mem_addr;
  logic [WORD_BITS-1:0] o_mem_wdata;
  logic                 i_mem_ack;
  logic [WORD_BITS-1:0] i_mem_rdata;

  modport master (
    output o_mem_req,
    output o_mem_we,
    output o_mem_addr,
    output o_mem_wdata,
    input  i_mem_ack,
    input  i_mem_rdata
  );

  modport slave (
    input  o_mem_req,
    input  o_mem_we,
    input  o_mem_addr,
    input  o_mem_wdata,
    output i_mem_ack,
    output i_mem_rdata
  );
endinterface

// File: rtl/dcache_mem_ctl.sv
// Data-cache line-fill / write-back engine: optional dirty-line write-back,
// then a 16-beat refill, returned to the cache with a one-cycle valid pulse.
module dcache_mem_ctl #(
  parameter int LINE_BITS = 512,
  parameter int WORD_BITS = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_miss,
  input  logic [ADDR_BITS-1:0] i_miss_addr,
  input  logic                 i_evict,
  input  logic [ADDR_BITS-1:0] i_evict_addr,
  input  logic [LINE_BITS-1:0] i_evict_data,
  output logic [LINE_BITS-1:0] o_line,
  output logic                 o_line_valid,
  output logic                 o_busy,
  dcache_mem_ctl_if.master     mem
);
  localparam int BEATS    = LINE_BITS / WORD_BITS;
  localparam int BW       = $clog2(BEATS);
  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int WSH      = $clog2(WORD_BITS / 8);

  typedef enum logic [1:0] {
    IDLE, WB, RD, RESP
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [ADDR_BITS-1:0] miss_base_q, miss_base_d;
  logic [ADDR_BITS-1:0] evict_base_q, evict_base_d;
  logic [LINE_BITS-1:0] victim_q, victim_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;

  logic [BW-1:0]        beat_inc;
  logic                 last;
  logic                 ack;
  logic [ADDR_BITS-1:0] beat_off;

  assign beat_inc = beat_q + 1'b1;
  assign last     = (beat_q == BW'(BEATS - 1));
  assign ack      = mem.i_mem_ack & req_q;
  assign beat_off = ADDR_BITS'(beat_inc) << WSH;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_base_d  = miss_base_q;
    evict_base_d = evict_base_q;
    victim_d     = victim_q;
    line_d       = line_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_miss) begin
          miss_base_d  = {i_miss_addr[ADDR_BITS-1:OFF_BITS], OFF_BITS'(0)};
          evict_base_d = {i_evict_addr[ADDR_BITS-1:OFF_BITS], OFF_BITS'(0)};
          victim_d     = i_evict_data;
          beat_d       = '0;
          busy_d       = 1'b1;
          req_d        = 1'b1;
          if (i_evict) begin
            state_d = WB;
            we_d    = 1'b1;
            addr_d  = evict_base_d;
            wdata_d = i_evict_data[WORD_BITS-1:0];
          end else begin
            state_d = RD;
            we_d    = 1'b0;
            addr_d  = miss_base_d;
            wdata_d = '0;
          end
        end
      end
      WB: begin
        if (ack) begin
          if (last) begin
            state_d = RD;
            beat_d  = '0;
            we_d    = 1'b0;
            addr_d  = miss_base_q;
            wdata_d = '0;
          end else begin
            beat_d  = beat_inc;
            addr_d  = evict_base_q + beat_off;
            wdata_d = victim_q[WORD_BITS*beat_inc +: WORD_BITS];
          end
        end
      end
      RD: begin
        if (ack) begin
          line_d[WORD_BITS*beat_q +: WORD_BITS] = mem.i_mem_rdata;
          if (last) begin
            state_d = RESP;
            beat_d  = '0;
            req_d   = 1'b0;
            valid_d = 1'b1;
          end else begin
            beat_d = beat_inc;
            addr_d = miss_base_q + beat_off;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset drops any in-flight transfer and the partial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      miss_base_q  <= '0;
      evict_base_q <= '0;
      victim_q     <= '0;
      line_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      miss_base_q  <= miss_base_d;
      evict_base_q <= evict_base_d;
      victim_q     <= victim_d;
      line_q       <= line_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign o_line          = line_q;
  assign o_line_valid    = valid_q;
  assign o_busy          = busy_q;
  assign mem.o_mem_req   = req_q;
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;
endmodule

// File: tb/tb_dcache_mem_ctl.sv
// Directed bench for dcache_mem_ctl with a wait-state memory model
// and a queue of expected bus beats.
module tb_dcache_mem_ctl;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_miss;
  logic [31:0]  i_miss_addr;
  logic         i_evict;
  logic [31:0]  i_evict_addr;
  logic [511:0] i_evict_data;
  logic [511:0] o_line;
  logic         o_line_valid;
  logic         o_busy;

  dcache_mem_ctl_if #(.ADDR_BITS(32), .WORD_BITS(32)) mif ();

  dcache_mem_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .i_miss       (i_miss),
    .i_miss_addr  (i_miss_addr),
    .i_evict      (i_evict),
    .i_evict_addr (i_evict_addr),
    .i_evict_data (i_evict_data),
    .o_line       (o_line),
    .o_line_valid (o_line_valid),
    .o_busy       (o_busy),
    .mem          (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          wait_n   = 1;
  int          ack_cnt  = 0;
  int          beats_done = 0;
  bit          stray    = 1'b0;
  bit          pend     = 1'b0;
  logic [31:0] rbase    = 32'h0;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: acks every wait_n-th requested cycle, checks each beat.
  always @(negedge clk) begin
    beat_t e;
    mif.i_mem_ack = 1'b0;
    if (mif.o_mem_req && !rst) begin
      if (pend) begin
        chk("hold_we", mif.o_mem_we, s_we);
        chk("hold_addr", mif.o_mem_addr, s_addr);
        chk("hold_wdata", mif.o_mem_wdata, s_wdata);
      end
      if (ack_cnt >= wait_n - 1) begin
        mif.i_mem_ack = 1'b1;
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
      if (mif.i_mem_ack) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_we", mif.o_mem_we, e.we);
          chk("beat_addr", mif.o_mem_addr, e.addr);
          if (e.we) chk("beat_wdata", mif.o_mem_wdata, e.wdata);
        end
        mif.i_mem_rdata = rbase + 32'(mif.o_mem_addr[5:2]);
        beats_done++;
      end
      pend    = !mif.i_mem_ack;
      s_we    = mif.o_mem_we;
      s_addr  = mif.o_mem_addr;
      s_wdata = mif.o_mem_wdata;
    end else begin
      pend    = 1'b0;
      ack_cnt = 0;
      if (stray) begin
        mif.i_mem_ack   = 1'b1;
        mif.i_mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic push_beats(input logic we, input logic [31:0] base,
                            input logic [511:0] data);
    beat_t b;
    for (int k = 0; k < 16; k++) begin
      b.we    = we;
      b.addr  = base + 32'(4 * k);
      b.wdata = we ? data[32*k +: 32] : 32'h0;
      exp_q.push_back(b);
    end
  endtask

  // Runs one miss; cycle 0 is the i_miss cycle. Optional second miss
  // pulse once 7 beats of the transfer have completed.
  task automatic run_miss(input string tag, input logic [31:0] maddr,
                          input logic ev, input logic [31:0] eaddr,
                          input logic [511:0] edata, input logic [31:0] rb,
                          input int exp_lat, input bit inject);
    int  n;
    int  b0;
    bit  done;
    done = 1'b0;
    rbase = rb;
    if (ev) push_beats(1'b1, eaddr & 32'hFFFF_FFC0, edata);
    push_beats(1'b0, maddr & 32'hFFFF_FFC0, '0);
    i_miss       = 1'b1;
    i_miss_addr  = maddr;
    i_evict      = ev;
    i_evict_addr = eaddr;
    i_evict_data = edata;
    b0 = beats_done;
    step();
    i_miss = 1'b0;
    n = 1;
    chk({tag, "_busy1"}, o_busy, 1'b1);
    while (!o_line_valid && n < 400) begin
      if (inject && !done && beats_done - b0 >= 7) begin
        i_miss      = 1'b1;
        i_miss_addr = 32'h0000_7700;
        done        = 1'b1;
      end else begin
        i_miss = 1'b0;
      end
      step();
      n++;
    end
    i_miss = 1'b0;
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_at_valid"}, o_busy, 1'b1);
    chk({tag, "_line"}, o_line, mk_line(rb));
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    step();
    chk({tag, "_valid_pulse"}, o_line_valid, 1'b0);
    chk({tag, "_idle_busy"}, o_busy, 1'b0);
    chk({tag, "_idle_req"}, mif.o_mem_req, 1'b0);
    chk({tag, "_line_hold"}, o_line, mk_line(rb));
  endtask

  initial begin
    logic [511:0] victim;
    logic [511:0] held;
    int           n;
    int           b0;
    rst = 1'b1;
    i_miss = 1'b0;
    i_miss_addr = '0;
    i_evict = 1'b0;
    i_evict_addr = '0;
    i_evict_data = '0;
    mif.i_mem_ack = 1'b0;
    mif.i_mem_rdata = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_req", mif.o_mem_req, 1'b0);
    chk("rst_we", mif.o_mem_we, 1'b0);
    chk("rst_addr", mif.o_mem_addr, 32'h0);
    chk("rst_wdata", mif.o_mem_wdata, 32'h0);
    chk("rst_line", o_line, 512'h0);
    chk("rst_valid", o_line_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);

    wait_n = 1;
    run_miss("refill", 32'h0000_1234, 1'b0, 32'h0, '0,
             32'hA000_0000, 17, 1'b0);

    for (int k = 0; k < 16; k++) victim[32*k +: 32] = 32'(k);
    run_miss("evict", 32'h0000_8000, 1'b1, 32'h0000_4010, victim,
             32'hC000_0000, 33, 1'b0);

    wait_n = 3;
    run_miss("waits", 32'h0000_3000, 1'b0, 32'h0, '0,
             32'hB000_0000, 49, 1'b0);
    wait_n = 1;

    run_miss("second_miss", 32'h0000_9A00, 1'b0, 32'h0, '0,
             32'hD000_0000, 17, 1'b1);
    step();
    chk("second_miss_no_restart", mif.o_mem_req, 1'b0);

    run_miss("same_addr", 32'h0000_6040, 1'b1, 32'h0000_6040, ~victim,
             32'hE000_0000, 33, 1'b0);

    // Abort in write-back right after beat 5 completes.
    push_beats(1'b1, 32'h0000_2000, victim);
    i_miss       = 1'b1;
    i_miss_addr  = 32'h0000_3300;
    i_evict      = 1'b1;
    i_evict_addr = 32'h0000_2000;
    i_evict_data = victim;
    b0 = beats_done;
    step();
    i_miss = 1'b0;
    n = 0;
    while (beats_done - b0 < 6 && n < 100) begin
      step();
      n++;
    end
    chk("abort_reached_beat6", beats_done - b0, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_req", mif.o_mem_req, 1'b0);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_valid", o_line_valid, 1'b0);
    exp_q.delete();
    run_miss("after_abort", 32'h0000_5678, 1'b0, 32'h0, '0,
             32'h1234_0000, 17, 1'b0);

    // Reset and miss together: the miss is dropped.
    rst = 1'b1;
    i_miss = 1'b1;
    i_miss_addr = 32'h0000_1000;
    i_evict = 1'b0;
    step();
    rst = 1'b0;
    i_miss = 1'b0;
    step();
    chk("rst_miss_req", mif.o_mem_req, 1'b0);
    chk("rst_miss_busy", o_busy, 1'b0);

    run_miss("pre_stray", 32'h0000_0F00, 1'b0, 32'h0, '0,
             32'h5500_0000, 17, 1'b0);
    held = o_line;
    stray = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stray_valid", o_line_valid, 1'b0);
      chk("stray_busy", o_busy, 1'b0);
      chk("stray_req", mif.o_mem_req, 1'b0);
    end
    stray = 1'b0;
    step();
    chk("stray_line", o_line, held);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
